sobol_sched: RTL and testbench
==============================

SOBOL_SCHED -- requirements
Module: sobol_sched

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters sharing one Sobol step unit.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req  input  N  per-requester level request for next point.
REQ-005 SHALL have port clr  input  N  per-requester sequence restart pulse.
REQ-006 SHALL have port m  input  36*N  per-requester direction numbers; slice k = m[36r+6k+5 : 36r+6k] is V[k] of requester r; k=0..4 used, k=5 ignored.
REQ-007 SHALL have port gnt  output  N  one-hot grant, high in CALC only.
REQ-008 SHALL have port vld  output  N  one-hot result strobe, high one cycle in RESP.
REQ-009 SHALL have port out  output  6  Sobol point, valid while any vld bit is high.
REQ-010 SHALL have port idx  output  5  sequence index of the point on out.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL keep per-requester state x[r] (6 bit) and n[r] (5 bit).
REQ-013 SHALL run FSM IDLE -> CALC -> RESP -> IDLE; IDLE stays if no req bit high; CALC and RESP last exactly one cycle each.
REQ-014 IDLE with any req high SHALL select winner g by round-robin, searching from last+1 mod N; last updates to g on entry to CALC.
REQ-015 CALC SHALL compute, via sobol_step: if n[g]==0 then p=0, else p = x[g] XOR V[c], c = index of lowest zero bit of n[g]-1; it SHALL sample m for g in this cycle only.
REQ-016 At CALC exit, SHALL store x[g]=p, n[g]=n[g]+1 with 31 wrapping to 0, and register out=p, idx=old n[g].
REQ-017 RESP SHALL assert vld[g]; out/idx hold their value until the next RESP.
REQ-018 Latency: req sampled in IDLE at edge t -> gnt in cycle t+1 -> vld in cycle t+2; a sole continuous requester is served every 3 cycles.
REQ-019 Deassertion of req[g] after grant SHALL NOT abort; vld[g] still pulses.
REQ-020 clr[r] high SHALL set x[r]=0, n[r]=0 at the next edge.
REQ-021 clr[g] during CALC SHALL take priority: state clears, RESP is still entered but vld stays 0 and out/idx are unchanged.
REQ-022 clr[g] during RESP SHALL NOT suppress vld (result already committed).
REQ-023 Requests from non-granted requesters SHALL be ignored until IDLE, with no loss: level req remains pending.

Reset
REQ-024 rst SHALL force state IDLE, gnt=0, vld=0, out=0, idx=0, busy=0, all x=0, all n=0, last=N-1 (requester 0 wins first); rst overrides clr and any in-flight operation, which produces no vld.

Configuration
REQ-025 With SOBOL_SCHED_FIXED_PRIO_EN defined, IDLE SHALL select the lowest-numbered high req bit (fixed priority) and last is unused; without it, round-robin per REQ-014.

Structure
REQ-026 Package sobol_pkg SHALL hold SOBOL_W=6, SOBOL_LEN=32, SOBOL_IDX_W=5, SOBOL_M_W=36, and the FSM state enum.
REQ-027 Combinational sub-module sobol_step (x_prev, n, m_slice -> p) SHALL hold the step arithmetic; one instance, shared.

Verification
REQ-028 Requester 0 alone, V[k]=32>>k, req held: out sequence 0,32,48,16 with idx 0,1,2,3, vld[0] every 3 cycles.
REQ-029 Same stimulus for 32 points: after idx 31, next point is idx 0 with out=0.
REQ-030 All four req held from reset: grant order 0,1,2,3,0; under SOBOL_SCHED_FIXED_PRIO_EN: 0,0,0.
REQ-031 clr[1] asserted in the CALC cycle of requester 1: no vld[1]; the next grant of 1 returns idx 0, out 0.
REQ-032 rst asserted in CALC: next cycle busy=0, vld=0, out=0, all sequences restart at idx 0.
REQ-033 req[2] dropped in its CALC cycle: vld[2] still pulses once next cycle, no further grant to 2.

Source files
------------

// File: rtl/sobol_pkg.sv
// Shared constants, FSM state type and small helpers for the Sobol scheduler.
// Configuration macro used by the scheduler: SOBOL_SCHED_FIXED_PRIO_EN.
package sobol_pkg;

    localparam int SOBOL_W     = 6;   // width of one Sobol point / direction number
    localparam int SOBOL_LEN   = 32;  // sequence length before the index wraps
    localparam int SOBOL_IDX_W = 5;   // width of the sequence index
    localparam int SOBOL_M_W   = 36;  // six 6-bit direction numbers per requester

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } sobol_state_e;

    // Position of the lowest zero bit of v. For v = all ones the result is 0,
    // which never occurs in use because n-1 is at most 30.
    function automatic logic [2:0] lowest_zero(input logic [SOBOL_IDX_W-1:0] v);
        logic [2:0] pos;
        logic       found;
        pos   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < SOBOL_IDX_W; i++) begin
            if (!v[i] && !found) begin
                pos   = 3'(i);
                found = 1'b1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/sobol_step.sv
// One Sobol recurrence step: given the previous point and its index, pick the
// direction number selected by the lowest zero bit of n-1 and fold it in.
// Point 0 of every sequence is defined as zero.
module sobol_step
    import sobol_pkg::*;
(
    input  logic [SOBOL_W-1:0]     x_prev,
    input  logic [SOBOL_IDX_W-1:0] n,
    input  logic [SOBOL_M_W-1:0]   m_slice,
    output logic [SOBOL_W-1:0]     p
);

    logic [SOBOL_IDX_W-1:0] n_minus_1;
    logic [2:0]             c;
    logic [SOBOL_W-1:0]     v_sel;

    // Select direction number V[c]; slot 5 of m_slice is never addressed.
    always_comb begin
        n_minus_1 = n - 5'd1;
        c         = lowest_zero(n_minus_1);
        v_sel     = '0;
        case (c)
            3'd0:    v_sel = m_slice[5:0];
            3'd1:    v_sel = m_slice[11:6];
            3'd2:    v_sel = m_slice[17:12];
            3'd3:    v_sel = m_slice[23:18];
            3'd4:    v_sel = m_slice[29:24];
            default: v_sel = '0;
        endcase
    end

    // Index 0 starts a fresh sequence at zero regardless of x_prev.
    always_comb begin
        p = '0;
        if (n != '0) begin
            p = x_prev ^ v_sel;
        end
    end

    logic unused_bits;
    assign unused_bits = ^m_slice[35:30];

endmodule

// File: rtl/sobol_sched.sv
// Arbitrated Sobol point generator: N requesters share one sobol_step unit.
// Each grant runs IDLE -> CALC -> RESP; CALC samples the winner's direction
// numbers and commits the new point, RESP strobes vld for the winner.
// Handshake: req is a level; a requester is served once per grant, gnt is high
// only in CALC, vld is a single-cycle strobe in RESP, and out/idx stay stable
// from that strobe until the next committed result.
// Macro SOBOL_SCHED_FIXED_PRIO_EN: lowest-numbered request wins instead of
// round-robin.
module sobol_sched
    import sobol_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           clr,
    input  logic [SOBOL_M_W*N-1:0] m,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           vld,
    output logic [SOBOL_W-1:0]     out,
    output logic [SOBOL_IDX_W-1:0] idx,
    output logic                   busy
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    sobol_state_e           state_q, state_d;
    logic [GW-1:0]          g_q, g_d;
    logic                   vld_ok_q, vld_ok_d;
    logic [SOBOL_W-1:0]     x_q [N];
    logic [SOBOL_IDX_W-1:0] n_q [N];
    logic [SOBOL_W-1:0]     out_q;
    logic [SOBOL_IDX_W-1:0] idx_q;
`ifndef SOBOL_SCHED_FIXED_PRIO_EN
    logic [GW-1:0]          last_q, last_d;
`endif

    logic [GW-1:0]          win;
    logic [N-1:0]           g_onehot;
    logic [SOBOL_W-1:0]     x_g;
    logic [SOBOL_IDX_W-1:0] n_g;
    logic [SOBOL_M_W-1:0]   m_g;
    logic                   clr_g;
    logic [SOBOL_W-1:0]     p;

`ifdef SOBOL_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered active request wins.
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                win   = GW'(i);
                found = 1'b1;
            end
        end
    end
`else
    // Round-robin: search starts one past the last winner and wraps.
    always_comb begin
        logic found;
        int   j;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(last_q) + i) % N;
            if (req[j] && !found) begin
                win   = GW'(j);
                found = 1'b1;
            end
        end
    end
`endif

    // Route the granted requester's state, direction numbers and clear.
    always_comb begin
        g_onehot = '0;
        x_g      = '0;
        n_g      = '0;
        m_g      = '0;
        clr_g    = 1'b0;
        for (int r = 0; r < N; r++) begin
            if (g_q == GW'(r)) begin
                g_onehot[r] = 1'b1;
                x_g         = x_q[r];
                n_g         = n_q[r];
                m_g         = m[SOBOL_M_W*r +: SOBOL_M_W];
                clr_g       = clr[r];
            end
        end
    end

    sobol_step u_step (
        .x_prev  (x_g),
        .n       (n_g),
        .m_slice (m_g),
        .p       (p)
    );

    // FSM next state: latch the winner on IDLE exit, decide on CALC exit
    // whether the response is visible (a clear of the winner cancels it).
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        vld_ok_d = vld_ok_q;
`ifndef SOBOL_SCHED_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_CALC;
                    g_d     = win;
`ifndef SOBOL_SCHED_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            ST_CALC: begin
                state_d  = ST_RESP;
                vld_ok_d = !clr_g;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            vld_ok_q <= 1'b0;
`ifndef SOBOL_SCHED_FIXED_PRIO_EN
            last_q   <= GW'(N - 1);
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            vld_ok_q <= vld_ok_d;
`ifndef SOBOL_SCHED_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    // Per-requester sequence state; a clear always beats the CALC commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                x_q[r] <= '0;
                n_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                if (clr[r]) begin
                    x_q[r] <= '0;
                    n_q[r] <= '0;
                end else if (state_q == ST_CALC && g_q == GW'(r)) begin
                    x_q[r] <= p;
                    n_q[r] <= n_q[r] + 5'd1;
                end
            end
        end
    end

    // Result registers, updated only by a committed (uncleared) CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            idx_q <= '0;
        end else if (state_q == ST_CALC && !clr_g) begin
            out_q <= p;
            idx_q <= n_g;
        end
    end

    assign gnt  = (state_q == ST_CALC) ? g_onehot : '0;
    assign vld  = (state_q == ST_RESP && vld_ok_q) ? g_onehot : '0;
    assign out  = out_q;
    assign idx  = idx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sobol_sched.sv
// Bench for sobol_sched: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model that
// derives each point in closed form from the Gray code of its index.
module tb_sobol_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   clr;
  logic [36*N-1:0] m;
  logic [N-1:0]   gnt;
  logic [N-1:0]   vld;
  logic [5:0]     out;
  logic [4:0]     idx;
  logic           busy;

  sobol_sched #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .clr  (clr),
    .m    (m),
    .gnt  (gnt),
    .vld  (vld),
    .out  (out),
    .idx  (idx),
    .busy (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Point n of a sequence = XOR of V[k] over the set bits of gray(n).
  function automatic logic [5:0] sobol_point(input int n, input logic [35:0] mv);
    int g;
    logic [5:0] p;
    g = n ^ (n >> 1);
    p = '0;
    for (int k = 0; k < 5; k++) begin
      if (g[k]) p = p ^ mv[6*k +: 6];
    end
    return p;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef SOBOL_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
`endif
    return 0;
  endfunction

  int         ph;        // cycles into the current grant: 0 idle, 1 calc, 2 resp
  int         nph;
  int         g_m;
  int         last_m;
  int         n_m [N];
  logic [5:0] out_m;
  logic [4:0] idx_m;
  bit         vok;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; g_m = 0; last_m = N - 1; out_m = '0; idx_m = '0; vok = 0;
      for (int r = 0; r < N; r++) n_m[r] = 0;
    end else begin
      nph = ph;
      if (ph == 0) begin
        if (req != '0) begin
          g_m = pick(req, last_m);
          last_m = g_m;
          nph = 1;
        end
      end else if (ph == 1) begin
        if (clr[g_m]) begin
          vok = 0;
        end else begin
          out_m = sobol_point(n_m[g_m], m[36*g_m +: 36]);
          idx_m = 5'(n_m[g_m]);
          n_m[g_m] = (n_m[g_m] + 1) % 32;
          vok = 1;
        end
        nph = 2;
      end else begin
        nph = 0;
      end
      for (int r = 0; r < N; r++) if (clr[r]) n_m[r] = 0;
      ph = nph;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [N-1:0] eg, ev;
    eg = (ph == 1) ? N'(1 << g_m) : '0;
    ev = (ph == 2 && vok) ? N'(1 << g_m) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("vld", 32'(vld), 32'(ev));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("out", 32'(out), 32'(out_m));
    chk("idx", 32'(idx), 32'(idx_m));
  end

  // ---------------- event logs ----------------
  int         gnt_log[$];
  logic [5:0] vo_q[$];
  logic [4:0] vi_q[$];
  int         vr_q[$];
  int         vc_q[$];
  logic [5:0] exp_q[$];

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (gnt != '0) gnt_log.push_back(onehot_idx(gnt));
    if (vld != '0) begin
      vo_q.push_back(out);
      vi_q.push_back(idx);
      vr_q.push_back(onehot_idx(vld));
      vc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    gnt_log.delete(); vo_q.delete(); vi_q.delete(); vr_q.delete(); vc_q.delete();
  endtask

  task automatic set_m_pow2();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 6; k++)
        m[36*r + 6*k +: 6] = (k < 5) ? 6'(32 >> k) : 6'd0;
  endtask

  task automatic set_m_rand();
    for (int r = 0; r < N; r++) begin
      m[36*r +: 32] = $urandom;
      m[36*r + 32 +: 4] = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_gnt(input logic [N-1:0] mask);
    for (int i = 0; i < 50 && (gnt & mask) == '0; i++) @(negedge clk);
    chk("wait_gnt", 32'((gnt & mask) != '0), 32'd1);
  endtask

  task automatic wait_vld(input int count, input int budget);
    for (int i = 0; i < budget && vo_q.size() < count; i++) @(negedge clk);
    chk("wait_vld", 32'(vo_q.size() >= count), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = '0; clr = '0; m = '0;
    set_m_pow2();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    rst = 1'b0;
    clear_logs();

    // Sole requester 0, held: 0,32,48,16 every 3 cycles, wraps after idx 31.
    req = 4'b0001;
    wait_vld(33, 200);
    req = '0;
    exp_q = '{6'd0, 6'd32, 6'd48, 6'd16};
    if (vo_q.size() >= 33) begin
      for (int i = 0; i < 4; i++) begin
        chk("a_out", 32'(vo_q[i]), 32'(exp_q[i]));
        chk("a_idx", 32'(vi_q[i]), i);
        chk("a_req", 32'(vr_q[i]), 32'd0);
      end
      for (int i = 1; i < 4; i++) chk("a_gap", 32'(vc_q[i] - vc_q[i-1]), 32'd3);
      chk("a_idx31", 32'(vi_q[31]), 32'd31);
      chk("a_out31", 32'(vo_q[31]), 32'd2);
      chk("a_wrap_idx", 32'(vi_q[32]), 32'd0);
      chk("a_wrap_out", 32'(vo_q[32]), 32'd0);
    end
    repeat (3) @(negedge clk);

    // All four requesting from reset: grant order.
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 60 && gnt_log.size() < 5; i++) @(negedge clk);
    chk("b_count", 32'(gnt_log.size() >= 5), 32'd1);
`ifdef SOBOL_SCHED_FIXED_PRIO_EN
    exp_q = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
`else
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
`endif
    if (gnt_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("b_order", 32'(gnt_log[i]), 32'(exp_q[i]));

    // Clear of requester 1 during its CALC suppresses the response.
    do_reset();
    req = 4'b0010;
    wait_vld(3, 30);
    wait_gnt(4'b0010);
    clr = 4'b0010;
    @(negedge clk);
    clr = '0;
    chk("c_no_vld", 32'(vld), 32'd0);
    chk("c_busy", 32'(busy), 32'd1);
    wait_vld(4, 30);
    if (vo_q.size() >= 4) begin
      chk("c_prev_idx", 32'(vi_q[2]), 32'd2);
      chk("c_idx", 32'(vi_q[3]), 32'd0);
      chk("c_out", 32'(vo_q[3]), 32'd0);
    end

    // Reset during CALC aborts the operation and restarts every sequence.
    do_reset();
    req = 4'hF;
    wait_vld(6, 60);
    wait_gnt(4'hF);
    rst = 1'b1;
    @(negedge clk);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_vld", 32'(vld), 32'd0);
    chk("d_out", 32'(out), 32'd0);
    chk("d_idx", 32'(idx), 32'd0);
    rst = 1'b0;
    clear_logs();
    wait_vld(1, 20);
    if (vo_q.size() >= 1) begin
      chk("d_first_req", 32'(vr_q[0]), 32'd0);
      chk("d_first_idx", 32'(vi_q[0]), 32'd0);
    end

    // Requester 2 drops req in its CALC cycle: one vld, no further grant.
    do_reset();
    req = 4'b0100;
    wait_gnt(4'b0100);
    req = '0;
    @(negedge clk);
    chk("e_vld", 32'(vld), 32'b0100);
    repeat (6) @(negedge clk);
    chk("e_grants", 32'(gnt_log.size()), 32'd1);

    // Randomized traffic, clears and occasional resets with new direction numbers.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        set_m_rand();
      end else begin
        rst = 1'b0;
      end
      req = N'($urandom_range(0, 15));
      clr = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : '0;
    end
    @(negedge clk);
    rst = 1'b0; req = '0; clr = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
